// File: rtl/rib_rr_arbiter_pkg.sv
// Shared RIB bus constants: request levels, bus widths, arbiter FSM encoding.
package rib_rr_arbiter_pkg;

  localparam logic RIB_REQ  = 1'b1;
  localparam logic RIB_NREQ = 1'b0;

  localparam int MemAddrBus      = 32;
  localparam int MemBus          = 32;
  localparam int RIB_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } rib_state_t;

endpackage

// File: rtl/rib_rr_arbiter_rr_pick.sv
// Round-robin priority picker: one-hot grant to the first requester after ptr.
// Purely combinational; no backpressure.
module rib_rr_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_rr_arbiter.sv
// RIB round-robin arbiter: req in IDLE -> s_req next cycle, s_ack -> m_ack next cycle.
// Slave stalls are absorbed in BUSY until ack or timeout; requests are ignored outside IDLE.
module rib_rr_arbiter
  import rib_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = MemAddrBus,
  parameter int DATA_W      = MemBus,
  parameter int TIMEOUT     = RIB_TIMEOUT_DEF,
  parameter int CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
  output logic [DATA_W-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic                          m_err_o,
  output logic                          s_req_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_data_o,
  input  logic [DATA_W-1:0]             s_data_i,
  input  logic                          s_ack_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          hold_flag_o,
  output logic                          busy_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  rib_state_t             state, state_d;
  logic [NUM_MASTERS-1:0] pick, grant_d, ack_d;
  logic [PW-1:0]          rr_ptr, ptr_d, own_idx;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   s_req_d, s_we_d, err_d, hold_d, timeout_hit;
  logic [ADDR_W-1:0]      addr_d;
  logic [DATA_W-1:0]      wdata_d, rdata_d;

  rib_rr_arbiter_rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_pick (
    .req   (m_req_i),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_o[i]) own_idx = PW'(i);
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign busy_o      = (state != IDLE);

  always_comb begin
    state_d = state;
    grant_d = grant_o;
    ptr_d   = rr_ptr;
    cnt_d   = cnt;
    s_req_d = s_req_o;
    s_we_d  = s_we_o;
    addr_d  = s_addr_o;
    wdata_d = s_data_o;
    rdata_d = m_data_o;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (|m_req_i) begin
          state_d = BUSY;
          grant_d = pick;
          s_req_d = RIB_REQ;
          cnt_d   = '0;
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick[i]) begin
              s_we_d  = m_we_i[i];
              addr_d  = m_addr_i[i*ADDR_W +: ADDR_W];
              wdata_d = m_data_i[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      BUSY: begin
        cnt_d = cnt + CNT_W'(1);
        // A real ack always beats a coincident timeout.
        if (s_ack_i) begin
          rdata_d = s_we_o ? '0 : s_data_i;
          ack_d   = grant_o;
          s_req_d = RIB_NREQ;
          ptr_d   = own_idx;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          ack_d   = grant_o;
          err_d   = 1'b1;
          s_req_d = RIB_NREQ;
          ptr_d   = own_idx;
          state_d = RESP;
        end
      end
      RESP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        s_req_d = RIB_NREQ;
        state_d = IDLE;
      end
    endcase
    // m0's request is stale during its own RESP cycle, so it must not re-raise the stall.
    hold_d = ((state_d != IDLE) && !grant_d[0]) ||
             (m_req_i[0] && !grant_d[0] && !((state == RESP) && grant_o[0]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant_o     <= '0;
      rr_ptr      <= PW'(NUM_MASTERS - 1);
      cnt         <= '0;
      s_req_o     <= 1'b0;
      s_we_o      <= 1'b0;
      s_addr_o    <= '0;
      s_data_o    <= '0;
      m_data_o    <= '0;
      m_ack_o     <= '0;
      m_err_o     <= 1'b0;
      hold_flag_o <= 1'b0;
    end else begin
      state       <= state_d;
      grant_o     <= grant_d;
      rr_ptr      <= ptr_d;
      cnt         <= cnt_d;
      s_req_o     <= s_req_d;
      s_we_o      <= s_we_d;
      s_addr_o    <= addr_d;
      s_data_o    <= wdata_d;
      m_data_o    <= rdata_d;
      m_ack_o     <= ack_d;
      m_err_o     <= err_d;
      hold_flag_o <= hold_d;
    end
  end

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Bench for rib_rr_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rib_rr_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NM-1:0]    m_req_i = '0;
  logic [NM-1:0]    m_we_i = '0;
  logic [NM*AW-1:0] m_addr_i = '0;
  logic [NM*DW-1:0] m_data_i = '0;
  logic [DW-1:0]    s_data_i = '0;
  logic             s_ack_i = 1'b0;

  logic [DW-1:0] m_data_o;
  logic [NM-1:0] m_ack_o, grant_o;
  logic          m_err_o, s_req_o, s_we_o, hold_flag_o, busy_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rib_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .hold_flag_o(hold_flag_o), .busy_o(busy_o)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  // Transaction-level reference: phase 0 idle, 1 waiting on slave, 2 response.
  int            ph = 0, oph = 0, own = 0, ptr = NM - 1, waited = 0;
  bit            hit;
  logic [NM-1:0] e_ack = '0, e_grant = '0;
  logic          e_err = 0, e_req = 0, e_we = 0, e_hold = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;

  task automatic finish_txn();
    e_ack = NM'(1 << own);
    e_req = 1'b0;
    ptr   = own;
    ph    = 2;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph = 0; own = 0; ptr = NM - 1; waited = 0;
      e_ack = '0; e_grant = '0; e_err = 0; e_req = 0; e_we = 0; e_hold = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else begin
      oph   = ph;
      e_ack = '0;
      e_err = 1'b0;
      if (ph == 0) begin
        hit = 0;
        for (int k = 1; k <= NM; k++) begin
          if (!hit && m_req_i[(ptr + k) % NM]) begin
            hit = 1;
            own = (ptr + k) % NM;
          end
        end
        if (hit) begin
          ph      = 1;
          waited  = 0;
          e_req   = 1'b1;
          e_grant = NM'(1 << own);
          e_we    = m_we_i[own];
          e_addr  = m_addr_i[own*AW +: AW];
          e_wdata = m_data_i[own*DW +: DW];
        end
      end else if (ph == 1) begin
        waited++;
        if (s_ack_i) begin
          e_rdata = e_we ? '0 : s_data_i;
          finish_txn();
        end else if (waited == TO) begin
          e_rdata = '0;
          e_err   = 1'b1;
          finish_txn();
        end
      end else begin
        ph      = 0;
        e_grant = '0;
      end
      // Core stalls while another master owns the bus, or while m0 waits for a grant.
      e_hold = (ph != 0 && own != 0) ||
               (m_req_i[0] && !(ph != 0 && own == 0) && !(oph == 2 && own == 0));
    end
  end

  always @(negedge clk) begin
    chk("outputs {s_req,s_we,s_addr,s_data,m_data,m_ack,m_err,grant,hold,busy}",
        {s_req_o, s_we_o, s_addr_o, s_data_o, m_data_o, m_ack_o, m_err_o, grant_o, hold_flag_o, busy_o},
        {e_req, e_we, e_addr, e_wdata, e_rdata, e_ack, e_err, e_grant, e_hold, (ph != 0)});
  end

  int            n;
  int            ack_cyc[$];
  logic [NM-1:0] ack_val[$];
  logic [NM-1:0] rr_exp[4];
  bit            quiet;

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

    repeat (3) @(posedge clk);
    #1;
    chk("reset s_req", s_req_o, 0);
    chk("reset grant", grant_o, 0);
    chk("reset busy/hold/ack", {busy_o, hold_flag_o, m_ack_o, m_err_o}, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single read by m1, slave acks two cycles after s_req.
    m_req_i = 3'b010;
    m_addr_i[1*AW +: AW] = 32'h1000_0004;
    step();
    chk("read s_req cycle1", s_req_o, 1);
    chk("read s_addr", s_addr_o, 32'h1000_0004);
    chk("read grant", grant_o, 3'b010);
    m_req_i = '0;
    step();
    step();
    s_ack_i  = 1'b1;
    s_data_i = 32'hDEAD_BEEF;
    step();
    chk("read m_ack cycle4", m_ack_o, 3'b010);
    chk("read m_data", m_data_o, 32'hDEAD_BEEF);
    chk("read m_err", m_err_o, 0);
    s_ack_i = 1'b0;
    step();
    chk("read ack pulse ends", {m_ack_o, grant_o}, 0);

    // Timeout on m2 write with a silent slave.
    m_req_i = 3'b100;
    m_we_i  = 3'b100;
    m_addr_i[2*AW +: AW] = 32'h5000_0000;
    m_data_i[2*DW +: DW] = 32'h0000_CAFE;
    step();
    chk("timeout capture", {s_req_o, s_we_o, s_addr_o, s_data_o}, {1'b1, 1'b1, 32'h5000_0000, 32'h0000_CAFE});
    m_req_i = '0;
    m_we_i  = '0;
    n = 0;
    while (s_req_o && n < 20) begin
      n++;
      step();
    end
    chk("timeout busy cycles", n, TO);
    chk("timeout ack/err/data", {m_ack_o, m_err_o, m_data_o}, {3'b100, 1'b1, 32'h0});
    step();
    chk("timeout err pulse ends", {m_ack_o, m_err_o}, 0);

    // Ack arrives in the same BUSY cycle the timeout would fire.
    m_req_i = 3'b010;
    step();
    m_req_i = '0;
    repeat (TO - 1) step();
    chk("collision still waiting", s_req_o, 1);
    s_ack_i  = 1'b1;
    s_data_i = 32'h0000_1234;
    step();
    chk("collision ack/err/data", {m_ack_o, m_err_o, m_data_o}, {3'b010, 1'b0, 32'h0000_1234});
    s_ack_i = 1'b0;

    // Round robin with all masters requesting and a zero-wait slave.
    do_reset();
    m_req_i = 3'b111;
    s_ack_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (m_ack_o != 0) begin
        ack_cyc.push_back(k);
        ack_val.push_back(m_ack_o);
      end
    end
    m_req_i = '0;
    s_ack_i = 1'b0;
    chk("rr ack count", ack_val.size(), 4);
    for (int i = 0; i < ack_val.size() && i < 4; i++) begin
      chk("rr grant order", ack_val[i], rr_exp[i]);
      if (i > 0) chk("rr ack spacing", ack_cyc[i] - ack_cyc[i-1], 3);
    end

    // m2 owns the bus while m0 waits, then m0 alone.
    do_reset();
    m_req_i = 3'b100;
    step();
    chk("hold m2 grant", {grant_o, hold_flag_o}, {3'b100, 1'b1});
    m_req_i = 3'b101;
    step();
    chk("hold m2 busy", hold_flag_o, 1);
    step();
    s_ack_i = 1'b1;
    step();
    chk("hold m2 resp", {m_ack_o, hold_flag_o}, {3'b100, 1'b1});
    s_ack_i = 1'b0;
    m_req_i = 3'b001;
    step();
    chk("hold m0 waiting", {grant_o, hold_flag_o}, {3'b000, 1'b1});
    step();
    chk("hold m0 granted", {grant_o, hold_flag_o}, {3'b001, 1'b0});
    s_ack_i = 1'b1;
    step();
    chk("hold m0 ack cycle", {m_ack_o, hold_flag_o}, {3'b001, 1'b0});
    for (int k = 0; k < 9; k++) begin
      step();
      chk("hold m0 alone", hold_flag_o, 0);
    end
    s_ack_i = 1'b0;
    m_req_i = '0;

    // Reset in the middle of a BUSY cycle.
    do_reset();
    m_req_i = 3'b010;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("async reset outputs", {s_req_o, grant_o, hold_flag_o, m_ack_o, busy_o}, 0);
    m_req_i = 3'b111;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("after reset m0 first", grant_o, 3'b001);
    m_req_i = '0;

    // Randomized traffic, with occasional silent-slave stretches to reach timeouts.
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) quiet = ($urandom_range(0, 3) == 0);
      m_req_i  = NM'($urandom);
      m_we_i   = NM'($urandom);
      m_addr_i = {$urandom, $urandom, $urandom};
      m_data_i = {$urandom, $urandom, $urandom};
      s_data_i = $urandom;
      s_ack_i  = !quiet && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
